// File: rtl/rr_arb_mux.sv
// rr_arb_mux
//   N-channel, WIDTH-bit arbitrated multiplexer with valid/ready handshakes
//   and a single registered output stage. The channel is chosen by a
//   round-robin arbiter (MODE=0), by a fixed-priority arbiter where the
//   lowest index wins (MODE=1), or by force_sel when force_en is high.
//   It sustains one word per cycle: a new word can be accepted in the same
//   cycle that the held word drains.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_data    N packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel word-present flags
//   in_ready   per-channel accept strobe (one-hot or zero), combinational
//   force_en   bypass the arbiter and use force_sel
//   force_sel  forced channel index (indices >= N are never granted)
//   out_data   registered output word
//   out_valid  out_data holds a valid word
//   out_ready  consumer takes out_data this cycle
//   out_sel    channel index of the word held in out_data
//
// SELW must equal clog2(N).
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               force_en,
  input  logic [SELW-1:0]    force_sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

  // Returns {found, index} of the lowest set bit of mask.
  function automatic logic [SELW:0] pick_lowest(input logic [N-1:0] mask);
    logic [SELW:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) r = {1'b1, SELW'(i)};
    end
    return r;
  endfunction

  // Next round-robin pointer: one past the granted channel, modulo N.
  function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] idx);
    return (idx == SELW'(N - 1)) ? '0 : idx + SELW'(1);
  endfunction

  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] data_p0;
  logic [SELW-1:0]  sel_p0;
  logic             vld_p0;

  logic             load;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [N-1:0]     grant_vec;
  logic [N-1:0]     hi_mask;
  logic [SELW:0]    hi_pick;
  logic [SELW:0]    lo_pick;
  logic [WIDTH-1:0] grant_word;

  // Output register can take a word when empty or when it drains this cycle.
  assign load = ~vld_p0 | out_ready;

  // Round-robin is done as two lowest-index searches: first among valid
  // channels at or above ptr, then, if none, among all valid channels.
  // That is the same as scanning ptr..N-1 and wrapping to 0..ptr-1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    hi_mask   = '0;
    hi_pick   = '0;
    lo_pick   = '0;
    if (force_en) begin
      for (int i = 0; i < N; i++) begin
        if (force_sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        hi_mask[i] = in_valid[i] && (SELW'(i) >= ptr);
      end
      lo_pick = pick_lowest(in_valid);
      hi_pick = pick_lowest(hi_mask);
      if (MODE == 0 && hi_pick[SELW]) {grant_vld, grant_idx} = hi_pick;
      else                            {grant_vld, grant_idx} = lo_pick;
    end
  end

  always_comb begin
    grant_vec  = '0;
    grant_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_vld && grant_idx == SELW'(i)) begin
        grant_vec[i] = 1'b1;
        grant_word   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by reset_n so that no channel sees an accept while reset is held.
  assign in_ready = {N{reset_n & load}} & grant_vec;

  // ---- stage p0: output register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p0 <= '0;
      sel_p0  <= '0;
      vld_p0  <= 1'b0;
      ptr     <= '0;
    end else if (load) begin
      if (grant_vld) begin
        data_p0 <= grant_word;
        sel_p0  <= grant_idx;
        vld_p0  <= 1'b1;
        ptr     <= next_ptr(grant_idx);
      end else begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign out_data  = data_p0;
  assign out_sel   = sel_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: a round-robin N=4 instance and a fixed-priority
// N=4 instance share one stimulus set; an N=3, WIDTH=8 round-robin instance
// has its own. Directed per-cycle vectors with hand-computed results.
module tb_rr_arb_mux;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;

  logic [127:0] in_data;
  logic [3:0]   in_valid = '0;
  logic         force_en = 1'b0;
  logic [1:0]   force_sel = '0;
  logic         out_ready = 1'b0;

  logic [3:0]   rr_in_ready, fp_in_ready;
  logic [31:0]  rr_out_data, fp_out_data;
  logic         rr_out_valid, fp_out_valid;
  logic [1:0]   rr_out_sel, fp_out_sel;

  logic [23:0]  n3_in_data;
  logic [2:0]   n3_in_valid = '0;
  logic         n3_force_en = 1'b0;
  logic [1:0]   n3_force_sel = '0;
  logic         n3_out_ready = 1'b0;
  logic [2:0]   n3_in_ready;
  logic [7:0]   n3_out_data;
  logic         n3_out_valid;
  logic [1:0]   n3_out_sel;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(32), .N(4), .SELW(2), .MODE(0)) u_rr (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(out_ready),
    .out_sel(rr_out_sel));

  rr_arb_mux #(.WIDTH(32), .N(4), .SELW(2), .MODE(1)) u_fp (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_in_ready), .force_en(force_en), .force_sel(force_sel),
    .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(out_ready),
    .out_sel(fp_out_sel));

  rr_arb_mux #(.WIDTH(8), .N(3), .SELW(2), .MODE(0)) u_n3 (
    .clk(clk), .reset_n(reset_n), .in_data(n3_in_data), .in_valid(n3_in_valid),
    .in_ready(n3_in_ready), .force_en(n3_force_en), .force_sel(n3_force_sel),
    .out_data(n3_out_data), .out_valid(n3_out_valid), .out_ready(n3_out_ready),
    .out_sel(n3_out_sel));

  function automatic logic [31:0] word4(input logic [1:0] ch);
    return 32'h1000_0001 * (32'(ch) + 32'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       fe;
    logic [1:0] fs;
    logic       ordy;
    logic [3:0] rdy;   // expected in_ready before the edge
    logic       ov;    // expected out_valid after the edge
    logic [1:0] os;    // expected out_sel after the edge
  } vec_t;

  vec_t tbl[21];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = word4(2'(i));
    n3_in_data = {8'hC3, 8'hB2, 8'hA1};

    //           valid    fe    fs    ordy  rdy      ov    os
    tbl[0]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[7]  = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[8]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[9]  = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[10] = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[11] = '{4'b1001, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[12] = '{4'b0111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[13] = '{4'b0111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[14] = '{4'b0111, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[15] = '{4'b0111, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[16] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[17] = '{4'b0110, 1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 2'd1};
    tbl[18] = '{4'b0110, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[19] = '{4'b0110, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[20] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd2};

    // Reset state before any clock edge.
    #2;
    chk("reset_out_valid", 64'(rr_out_valid), 64'd0);
    chk("reset_out_data", 64'(rr_out_data), 64'd0);
    chk("reset_out_sel", 64'(rr_out_sel), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin instance, one vector per cycle.
    for (int k = 0; k < 21; k++) begin
      in_valid  = tbl[k].valid;
      force_en  = tbl[k].fe;
      force_sel = tbl[k].fs;
      out_ready = tbl[k].ordy;
      #1;
      chk($sformatf("rr_in_ready[%0d]", k), 64'(rr_in_ready), 64'(tbl[k].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("rr_out_valid[%0d]", k), 64'(rr_out_valid), 64'(tbl[k].ov));
      chk($sformatf("rr_out_sel[%0d]", k), 64'(rr_out_sel), 64'(tbl[k].os));
      chk($sformatf("rr_out_data[%0d]", k), 64'(rr_out_data), 64'(word4(tbl[k].os)));
      @(negedge clk);
    end

    // Mid-run asynchronous reset with a word held in the output register.
    in_valid = 4'b1111; force_en = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_valid", 64'(rr_out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rr_out_valid), 64'd0);
    chk("async_rst_data", 64'(rr_out_data), 64'd0);
    chk("async_rst_sel", 64'(rr_out_sel), 64'd0);
    chk("async_rst_ready", 64'(rr_in_ready), 64'd0);
    chk("async_rst_fp_ready", 64'(fp_in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(rr_in_ready), 64'b0001);
    @(posedge clk); #1;
    chk("post_rst_sel", 64'(rr_out_sel), 64'd0);
    chk("post_rst_valid", 64'(rr_out_valid), 64'd1);

    // Fixed priority: ch1 starves ch3 until ch1 drops.
    @(negedge clk);
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("fp_ready_1010[%0d]", k), 64'(fp_in_ready), 64'b0010);
      @(posedge clk); #1;
      chk($sformatf("fp_sel_1010[%0d]", k), 64'(fp_out_sel), 64'd1);
      chk($sformatf("fp_data_1010[%0d]", k), 64'(fp_out_data), 64'(word4(2'd1)));
      @(negedge clk);
    end
    in_valid = 4'b1000;
    #1;
    chk("fp_ready_1000", 64'(fp_in_ready), 64'b1000);
    @(posedge clk); #1;
    chk("fp_sel_1000", 64'(fp_out_sel), 64'd3);
    chk("fp_data_1000", 64'(fp_out_data), 64'(word4(2'd3)));
    @(negedge clk);
    in_valid = 4'b0000;

    // N=3 instance: wrap 2 -> 0, byte slicing, out-of-range force_sel.
    n3_in_valid = 3'b111;
    n3_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] es;
      logic [7:0] ed;
      es = 2'(k % 3);
      ed = (es == 2'd0) ? 8'hA1 : (es == 2'd1) ? 8'hB2 : 8'hC3;
      #1;
      chk($sformatf("n3_ready[%0d]", k), 64'(n3_in_ready), 64'(3'b001 << es));
      @(posedge clk); #1;
      chk($sformatf("n3_sel[%0d]", k), 64'(n3_out_sel), 64'(es));
      chk($sformatf("n3_data[%0d]", k), 64'(n3_out_data), 64'(ed));
      @(negedge clk);
    end
    n3_force_en = 1'b1;
    n3_force_sel = 2'd3;
    #1;
    chk("n3_force3_ready", 64'(n3_in_ready), 64'd0);
    @(posedge clk); #1;
    chk("n3_force3_valid", 64'(n3_out_valid), 64'd0);
    chk("n3_force3_data_hold", 64'(n3_out_data), 64'hA1);
    @(negedge clk);
    n3_force_sel = 2'd2;
    #1;
    chk("n3_force2_ready", 64'(n3_in_ready), 64'b100);
    @(posedge clk); #1;
    chk("n3_force2_valid", 64'(n3_out_valid), 64'd1);
    chk("n3_force2_data", 64'(n3_out_data), 64'hC3);
    chk("n3_force2_sel", 64'(n3_out_sel), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
